// File: rtl/r_format_operand_fetch.sv
// r_format_operand_fetch
// Operand-fetch stage for R-format instructions. Owns the register file,
// decodes rs/rt/rd/funct and hands operands to execute over valid/ready.
// Optional macro OPERAND_BYPASS_EN: forward a same-cycle write-back into the
// operands captured during READ.
module r_format_operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_input,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instruction,
  input  logic                  write_enabled,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic [3:0]            ALU_operation,
  output logic                  illegal_instruction
);

  typedef enum logic [1:0] {IDLE, READ, VALID} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [5:0]            r_opcode;
  logic [ADDR_WIDTH-1:0] r_rs;
  logic [ADDR_WIDTH-1:0] r_rt;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [5:0]            r_funct;

  logic [DATA_WIDTH-1:0] r_regFile [2**ADDR_WIDTH];

  logic [DATA_WIDTH-1:0] r_rsData;
  logic [DATA_WIDTH-1:0] r_rtData;
  logic [ADDR_WIDTH-1:0] r_rdAddress;
  logic [3:0]            r_aluOp;
  logic                  r_illegal;

  logic [DATA_WIDTH-1:0] w_rsData;
  logic [DATA_WIDTH-1:0] w_rtData;
  logic [3:0]            w_aluOp;
  logic                  w_illegal;
  logic                  w_accept;

  assign w_accept = instr_valid && instr_ready;

  // State register; reset always lands in IDLE and drops any in-flight work
  always_ff @(posedge clk) begin
    if (reset_input) r_state <= IDLE;
    else             r_state <= w_nextState;
  end

  // Next-state and handshake outputs; instr_ready is masked while reset is high
  always_comb begin
    w_nextState = r_state;
    instr_ready = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = !reset_input;
        if (instr_valid) w_nextState = READ;
      end
      READ: w_nextState = VALID;
      VALID: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch only the instruction fields the stage actually uses, on acceptance
  always_ff @(posedge clk) begin
    if (reset_input) begin
      r_opcode <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_funct  <= '0;
    end else if (w_accept) begin
      r_opcode <= instruction[31:26];
      r_rs     <= ADDR_WIDTH'(instruction[25:21]);
      r_rt     <= ADDR_WIDTH'(instruction[20:16]);
      r_rd     <= ADDR_WIDTH'(instruction[15:11]);
      r_funct  <= instruction[5:0];
    end
  end

  // Register file write port; address 0 is never written so it reads as zero
  always_ff @(posedge clk) begin
    if (reset_input) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) r_regFile[i] <= '0;
    end else if (write_enabled && (write_address != '0)) begin
      r_regFile[write_address] <= write_data;
    end
  end

  // Source operand read, optionally forwarding a write landing this same cycle
  always_comb begin
    w_rsData = (r_rs == '0) ? '0 : r_regFile[r_rs];
    w_rtData = (r_rt == '0) ? '0 : r_regFile[r_rt];
`ifdef OPERAND_BYPASS_EN
    if (write_enabled && (write_address != '0) && (write_address == r_rs)) w_rsData = write_data;
    if (write_enabled && (write_address != '0) && (write_address == r_rt)) w_rtData = write_data;
`endif
  end

  // funct to ALU opcode; anything outside the table or a nonzero opcode is illegal
  always_comb begin
    w_aluOp   = 4'b1111;
    w_illegal = 1'b1;
    if (r_opcode == 6'd0) begin
      w_illegal = 1'b0;
      case (r_funct)
        6'h20:   w_aluOp = 4'b0000;
        6'h22:   w_aluOp = 4'b0001;
        6'h24:   w_aluOp = 4'b0010;
        6'h25:   w_aluOp = 4'b0011;
        6'h2A:   w_aluOp = 4'b0100;
        6'h26:   w_aluOp = 4'b0101;
        6'h27:   w_aluOp = 4'b0110;
        default: begin
          w_aluOp   = 4'b1111;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  // Operand snapshot taken in READ and held untouched through VALID
  always_ff @(posedge clk) begin
    if (reset_input) begin
      r_rsData    <= '0;
      r_rtData    <= '0;
      r_rdAddress <= '0;
      r_aluOp     <= '0;
      r_illegal   <= 1'b0;
    end else if (r_state == READ) begin
      r_rsData    <= w_rsData;
      r_rtData    <= w_rtData;
      r_rdAddress <= r_rd;
      r_aluOp     <= w_aluOp;
      r_illegal   <= w_illegal;
    end
  end

  assign rs_data             = r_rsData;
  assign rt_data             = r_rtData;
  assign rd_address          = r_rdAddress;
  assign ALU_operation       = r_aluOp;
  assign illegal_instruction = r_illegal;

endmodule

// File: tb/tb_r_format_operand_fetch.sv
// Testbench for r_format_operand_fetch: directed scenarios with literal
// expectations followed by randomized traffic checked against a reference model.
module tb_r_format_operand_fetch;

  logic        clk;
  logic        reset_input;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        write_enabled;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rd_address;
  logic [3:0]  ALU_operation;
  logic        illegal_instruction;

  int passCount  = 0;
  int checkCount = 0;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  r_format_operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk                 (clk),
    .reset_input         (reset_input),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instruction         (instruction),
    .write_enabled       (write_enabled),
    .write_address       (write_address),
    .write_data          (write_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .rs_data             (rs_data),
    .rt_data             (rt_data),
    .rd_address          (rd_address),
    .ALU_operation       (ALU_operation),
    .illegal_instruction (illegal_instruction)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference decode table from the instruction format
  function automatic logic [4:0] modelDecode(input logic [31:0] ins);
    logic [3:0] op;
    logic       ill;
    op  = 4'hF;
    ill = 1'b1;
    if (ins[31:26] == 6'd0) begin
      ill = 1'b0;
      case (ins[5:0])
        6'h20: op = 4'd0;
        6'h22: op = 4'd1;
        6'h24: op = 4'd2;
        6'h25: op = 4'd3;
        6'h2A: op = 4'd4;
        6'h26: op = 4'd5;
        6'h27: op = 4'd6;
        default: begin op = 4'hF; ill = 1'b1; end
      endcase
    end
    return {ill, op};
  endfunction

  // Reference model: instruction phase (0 waiting, 1 fetching, 2 presenting),
  // an array of register values, and the expected snapshot
  int          mPhase = 0;
  logic [31:0] mRegs [32];
  logic [31:0] mInstr;
  logic [31:0] expRs, expRt;
  logic [4:0]  expRd;
  logic [3:0]  expOp;
  logic        expIll;

  initial begin
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mInstr = 0; expRs = 0; expRt = 0; expRd = 0; expOp = 0; expIll = 0;
  end

  always @(posedge clk) begin
    logic [4:0] rsA, rtA;
    logic [4:0] dec;
    if (reset_input) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mPhase = 0;
      expRs = 0; expRt = 0; expRd = 0; expOp = 0; expIll = 0;
    end else begin
      if (mPhase == 0) begin
        if (instr_valid) begin mInstr = instruction; mPhase = 1; end
      end else if (mPhase == 1) begin
        rsA   = mInstr[25:21];
        rtA   = mInstr[20:16];
        expRs = mRegs[rsA];
        expRt = mRegs[rtA];
        if (BYPASS && write_enabled && write_address != 0) begin
          if (write_address == rsA) expRs = write_data;
          if (write_address == rtA) expRt = write_data;
        end
        dec    = modelDecode(mInstr);
        expRd  = mInstr[15:11];
        expOp  = dec[3:0];
        expIll = dec[4];
        mPhase = 2;
      end else begin
        if (out_ready) mPhase = 0;
      end
      if (write_enabled && write_address != 0) mRegs[write_address] = write_data;
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    checkOutput("m_instr_ready", {31'd0, instr_ready}, {31'd0, (mPhase == 0) && !reset_input});
    checkOutput("m_out_valid", {31'd0, out_valid}, {31'd0, mPhase == 2});
    checkOutput("m_rs_data", rs_data, expRs);
    checkOutput("m_rt_data", rt_data, expRt);
    checkOutput("m_rd_address", {27'd0, rd_address}, {27'd0, expRd});
    checkOutput("m_alu_op", {28'd0, ALU_operation}, {28'd0, expOp});
    checkOutput("m_illegal", {31'd0, illegal_instruction}, {31'd0, expIll});
  end

  // One-cycle register write
  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    write_enabled = 1'b1; write_address = a; write_data = d;
    @(posedge clk); #1;
    write_enabled = 1'b0;
  endtask

  // Offer an instruction until accepted; returns during the READ cycle
  task automatic issueInstr(input logic [31:0] ins);
    bit got = 0;
    bit rdy;
    instr_valid = 1'b1; instruction = ins;
    for (int i = 0; i < 20 && !got; i++) begin
      rdy = instr_ready;
      @(posedge clk); #1;
      if (rdy) got = 1;
    end
    instr_valid = 1'b0;
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Fetch one instruction, check literal outputs one cycle after READ, then handshake
  task automatic fetchLit(input string name, input logic [31:0] ins, input logic [31:0] eRs,
                          input logic [31:0] eRt, input logic [4:0] eRd, input logic [3:0] eOp,
                          input logic eIll);
    issueInstr(ins);
    @(posedge clk); #1;
    checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({name, "_rs"}, rs_data, eRs);
    checkOutput({name, "_rt"}, rt_data, eRt);
    checkOutput({name, "_rd"}, {27'd0, rd_address}, {27'd0, eRd});
    checkOutput({name, "_op"}, {28'd0, ALU_operation}, {28'd0, eOp});
    checkOutput({name, "_ill"}, {31'd0, illegal_instruction}, {31'd0, eIll});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_done"}, {30'd0, out_valid, instr_ready}, 32'd1);
  endtask

  localparam logic [31:0] ADD312 = 32'h00221820;

  initial begin
    logic [5:0] functs [8];
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25;
    functs[4] = 6'h2A; functs[5] = 6'h26; functs[6] = 6'h27; functs[7] = 6'h3F;

    reset_input = 1'b1; instr_valid = 0; instruction = 0;
    write_enabled = 0; write_address = 0; write_data = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_input = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("reset_outs", {out_valid, illegal_instruction, ALU_operation, rd_address} , 11'd0);
    checkOutput("reset_rs", rs_data | rt_data, 32'd0);

    $display("[TB] directed: basic add");
    applyStimulus(5'd1, 32'd1);
    applyStimulus(5'd2, 32'd2);
    fetchLit("add", ADD312, 32'd1, 32'd2, 5'd3, 4'd0, 1'b0);

    $display("[TB] directed: r0 write ignored");
    applyStimulus(5'd0, 32'hDEADBEEF);
    fetchLit("sub_r0", 32'h00002022, 32'd0, 32'd0, 5'd4, 4'd1, 1'b0);

    $display("[TB] directed: back-pressure with write during VALID");
    issueInstr(ADD312);
    @(posedge clk); #1;
    applyStimulus(5'd1, 32'd7);
    for (int i = 0; i < 9; i++) begin
      checkOutput("bp_rs", rs_data, 32'd1);
      checkOutput("bp_flags", {30'd0, out_valid, instr_ready}, 32'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fetchLit("after_bp", ADD312, 32'd7, 32'd2, 5'd3, 4'd0, 1'b0);

    $display("[TB] directed: write in READ cycle");
    applyStimulus(5'd1, 32'd1);
    issueInstr(ADD312);
    applyStimulus(5'd1, 32'd3);
    checkOutput("byp_rs", rs_data, BYPASS ? 32'd3 : 32'd1);
    checkOutput("byp_rt", rt_data, 32'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("[TB] directed: illegal instructions");
    fetchLit("ill_op", 32'h8C220000, 32'd3, 32'd2, 5'd0, 4'hF, 1'b1);
    fetchLit("ill_fn", 32'h0022183F, 32'd3, 32'd2, 5'd3, 4'hF, 1'b1);

    $display("[TB] directed: reset during VALID");
    issueInstr(ADD312);
    @(posedge clk); #1;
    reset_input = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_flags", {30'd0, out_valid, instr_ready}, 32'd0);
    checkOutput("rst_mid_outs", {illegal_instruction, ALU_operation, rd_address}, 10'd0);
    checkOutput("rst_mid_data", rs_data | rt_data, 32'd0);
    reset_input = 1'b0;
    @(posedge clk); #1;
    fetchLit("rst_refetch", ADD312, 32'd0, 32'd0, 5'd3, 4'd0, 1'b0);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[5:0] = functs[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) != 0) ins[31:26] = 6'd0;
      instruction   = ins;
      instr_valid   = ($urandom_range(0, 2) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      write_enabled = ($urandom_range(0, 1) != 0);
      write_address = 5'($urandom_range(0, 7));
      write_data    = $urandom;
      reset_input   = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    instr_valid = 0; write_enabled = 0; reset_input = 0; out_ready = 1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
